// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong game blocks.
//   state_t         : match scheduler FSM encoding (3 bits)
//   EDG_*           : exit-edge codes reported by the motion controller
//   WIN_*           : winner codes shown by the display logic
package pingpong_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_WAIT = 3'd1,
    LAUNCH     = 3'd2,
    WAIT_ACK   = 3'd3,
    RALLY      = 3'd4,
    SCORE      = 3'd5,
    CHECK      = 3'd6,
    OVER       = 3'd7
  } state_t;

  localparam logic [1:0] EDG_NONE  = 2'b00;
  localparam logic [1:0] EDG_LEFT  = 2'b01;
  localparam logic [1:0] EDG_RIGHT = 2'b10;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame tick generator.
//   clk        : system clock
//   rst_n      : synchronous reset, active-high
//   frame_tick : registered one-cycle pulse, high while the prescaler holds
//                FRAME_DIV-1, i.e. once every FRAME_DIV cycles
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;

  // The tick is computed from the next prescaler value so the registered
  // pulse lines up exactly with the cycle the prescaler sits at LAST.
  always_comb begin
    presc_d = (presc_q == LAST) ? '0 : presc_q + 1'b1;
    tick_d  = (presc_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/rally_sched.sv
// Match-level scheduler for the ball-motion controller.
//   clk         : system clock
//   rst_n       : synchronous reset, ACTIVE-HIGH despite the name
//   key_start   : debounced player start key (level, rising edge used)
//   halt        : motion controller idle flag
//   edg         : exit edge of the finished rally (00 none, 01 left, 10 right)
//   start       : one-cycle launch request to the motion controller
//   serve_side  : 0 left serves, 1 right serves
//   score_l/r   : player scores, saturate at WIN_SCORE
//   game_over   : high while in OVER
//   winner      : 00 none, 01 left, 10 right
//   frame_tick  : free-running frame pulse
//
// Launch handshake: start is a one-cycle request; the motion controller
// accepts it by dropping halt. If halt is still high after ACK_TIMEOUT
// cycles of waiting, the request is re-issued, without limit. The rally is
// over on the first cycle halt is high again, and edg is captured then.
//
// SCORE_W must be wide enough that WIN_SCORE < 2**SCORE_W.
module rally_sched
  import pingpong_pkg::*;
#(
  parameter int FRAME_DIV   = 833333,
  parameter int SERVE_DLY   = 60,
  parameter int WIN_SCORE   = 11,
  parameter int SCORE_W     = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_start,
  input  logic               halt,
  input  logic [1:0]         edg,
  output logic               start,
  output logic               serve_side,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               frame_tick
);

  localparam int SD_W = (SERVE_DLY > 0) ? $clog2(SERVE_DLY + 1) : 1;
  localparam int RT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [SD_W-1:0]    SERVE_LOAD = SD_W'(SERVE_DLY);
  localparam logic [RT_W-1:0]    RETRY_LAST = RT_W'(ACK_TIMEOUT - 1);
  localparam logic [SCORE_W-1:0] WIN_Q      = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic               key_q;
  logic               key_rise;
  logic [SD_W-1:0]    serve_cnt_q, serve_cnt_d;
  logic [RT_W-1:0]    retry_q, retry_d;
  logic [1:0]         edg_q, edg_d;
  logic               start_q, start_d;
  logic               serve_side_q, serve_side_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic               game_over_q, game_over_d;

  frame_tick_gen #(
    .FRAME_DIV (FRAME_DIV)
  ) u_frame_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign key_rise = key_start & ~key_q;

  always_comb begin
    state_d      = state_q;
    serve_cnt_d  = serve_cnt_q;
    retry_d      = retry_q;
    edg_d        = edg_q;
    serve_side_d = serve_side_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    winner_d     = winner_q;

    unique case (state_q)
      IDLE, OVER: begin
        // A new game starts the same way from either state.
        if (key_rise) begin
          score_l_d    = '0;
          score_r_d    = '0;
          serve_side_d = 1'b0;
          winner_d     = WIN_NONE;
          serve_cnt_d  = SERVE_LOAD;
          state_d      = SERVE_WAIT;
        end
      end
      SERVE_WAIT: begin
        // Count stops at zero; launch waits there until the controller idles.
        if (serve_cnt_q == '0) begin
          if (halt) state_d = LAUNCH;
        end else if (frame_tick) begin
          serve_cnt_d = serve_cnt_q - 1'b1;
        end
      end
      LAUNCH: begin
        retry_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!halt) begin
          state_d = RALLY;
        end else begin
          retry_d = retry_q + 1'b1;
          if (retry_q == RETRY_LAST) state_d = LAUNCH;
        end
      end
      RALLY: begin
        if (halt) begin
          edg_d   = edg;
          state_d = SCORE;
        end
      end
      SCORE: begin
        // Ball leaving on one side scores for the opponent; the loser serves.
        if (edg_q == EDG_LEFT) begin
          if (score_r_q != WIN_Q) score_r_d = score_r_q + 1'b1;
          serve_side_d = 1'b0;
        end else if (edg_q == EDG_RIGHT) begin
          if (score_l_q != WIN_Q) score_l_d = score_l_q + 1'b1;
          serve_side_d = 1'b1;
        end
        state_d = CHECK;
      end
      CHECK: begin
        if (score_l_q == WIN_Q) begin
          winner_d = WIN_L;
          state_d  = OVER;
        end else if (score_r_q == WIN_Q) begin
          winner_d = WIN_R;
          state_d  = OVER;
        end else begin
          serve_cnt_d = SERVE_LOAD;
          state_d     = SERVE_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered state-decoded outputs, aligned with the state they describe.
    start_d     = (state_d == LAUNCH);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= IDLE;
      key_q        <= 1'b0;
      serve_cnt_q  <= '0;
      retry_q      <= '0;
      edg_q        <= EDG_NONE;
      start_q      <= 1'b0;
      serve_side_q <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= WIN_NONE;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_start;
      serve_cnt_q  <= serve_cnt_d;
      retry_q      <= retry_d;
      edg_q        <= edg_d;
      start_q      <= start_d;
      serve_side_q <= serve_side_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      game_over_q  <= game_over_d;
    end
  end

  assign start      = start_q;
  assign serve_side = serve_side_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign winner     = winner_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_rally_sched.sv
// Directed bench for rally_sched with FRAME_DIV=4, SERVE_DLY=2,
// WIN_SCORE=3, ACK_TIMEOUT=8. Inputs change and outputs are sampled 1 ns
// after each rising clock edge.
module tb_rally_sched;
  import pingpong_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_start = 1'b0;
  logic       halt = 1'b1;
  logic [1:0] edg = 2'b00;
  logic       start;
  logic       serve_side;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic [1:0] winner;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  rally_sched #(
    .FRAME_DIV   (4),
    .SERVE_DLY   (2),
    .WIN_SCORE   (3),
    .SCORE_W     (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_start  (key_start),
    .halt       (halt),
    .edg        (edg),
    .start      (start),
    .serve_side (serve_side),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over),
    .winner     (winner),
    .frame_tick (frame_tick)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until start is seen (bounded). Reports the frame ticks sampled
  // before it and how many samples after the last tick it arrived.
  task automatic wait_start(output bit found, output int ticks, output int gap);
    int last;
    found = 1'b0;
    ticks = 0;
    gap   = -1;
    last  = -100;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (start) begin
        found = 1'b1;
        gap   = i - last;
      end else if (frame_tick) begin
        ticks++;
        last = i;
      end
    end
  endtask

  // Called on the LAUNCH sample: controller accepts, plays, then halts with e.
  // Returns on the CHECK sample, where the new score is visible.
  task automatic do_rally(input logic [1:0] e);
    halt = 1'b0;
    step();
    step();
    step();
    halt = 1'b1;
    edg  = e;
    step();
    step();
    edg  = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic exp_tick;
    rst_n = 1'b1; halt = 1'b1; key_start = 1'b0; edg = 2'b00;
    repeat (3) step();
    n_tests++;
    if ({start, serve_side, score_l, score_r, game_over, winner, frame_tick} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {start, serve_side, score_l, score_r, game_over, winner, frame_tick});
    end
    n_tests++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required %0d", dut.state_q, IDLE);
    end
    rst_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp_tick = (i == 3) || (i == 7);
      n_tests++;
      if (frame_tick !== exp_tick) begin
        n_fail++;
        $display("FAIL tick_phase[%0d]: got %b required %b", i, frame_tick, exp_tick);
      end
    end
  endtask

  task automatic test_first_serve();
    bit found; int ticks; int gap;
    key_start = 1'b1;
    wait_start(found, ticks, gap);
    key_start = 1'b0;
    n_tests++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL first_start_seen: got %b required 1", found); end
    n_tests++;
    if (ticks !== 2) begin n_fail++; $display("FAIL first_start_ticks: got %0d required 2", ticks); end
    n_tests++;
    if (gap !== 2) begin n_fail++; $display("FAIL first_start_gap: got %0d required 2", gap); end
    n_tests++;
    if ({serve_side, score_l, score_r} !== 9'd0) begin
      n_fail++;
      $display("FAIL first_serve_state: got side=%b l=%0d r=%0d required 0/0/0", serve_side, score_l, score_r);
    end
  endtask

  task automatic test_point();
    bit found; int ticks; int gap;
    halt = 1'b0;
    step();
    n_tests++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL start_one_cycle: got %b required 0", start); end
    step();
    step();
    halt = 1'b1;
    edg  = 2'b10;
    step();
    n_tests++;
    if (score_l !== 4'd0) begin n_fail++; $display("FAIL score_l_early: got %0d required 0", score_l); end
    step();
    edg = 2'b00;
    n_tests++;
    if ({score_l, score_r, serve_side} !== {4'd1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL point_right_edge: got l=%0d r=%0d side=%b required 1/0/1", score_l, score_r, serve_side);
    end
    wait_start(found, ticks, gap);
    n_tests++;
    if ({found, ticks[3:0], gap[3:0]} !== {1'b1, 4'd2, 4'd2}) begin
      n_fail++;
      $display("FAIL next_serve: got found=%b ticks=%0d gap=%0d required 1/2/2", found, ticks, gap);
    end
  endtask

  task automatic test_retry();
    logic exp_start;
    for (int i = 1; i <= 18; i++) begin
      step();
      exp_start = (i == 9) || (i == 18);
      n_tests++;
      if (start !== exp_start) begin
        n_fail++;
        $display("FAIL retry_start[%0d]: got %b required %b", i, start, exp_start);
      end
    end
    n_tests++;
    if ({score_l, score_r} !== {4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL retry_scores: got %0d/%0d required 1/0", score_l, score_r);
    end
  endtask

  task automatic test_replay();
    bit found; int ticks; int gap;
    logic [1:0] codes [2];
    codes[0] = 2'b00;
    codes[1] = 2'b11;
    for (int k = 0; k < 2; k++) begin
      do_rally(codes[k]);
      n_tests++;
      if ({score_l, score_r, serve_side} !== {4'd1, 4'd0, 1'b1}) begin
        n_fail++;
        $display("FAIL replay_%0d: got l=%0d r=%0d side=%b required 1/0/1", k, score_l, score_r, serve_side);
      end
      wait_start(found, ticks, gap);
      n_tests++;
      if (found !== 1'b1) begin n_fail++; $display("FAIL replay_relaunch_%0d: got %b required 1", k, found); end
    end
  endtask

  task automatic test_game_over();
    bit found; int ticks; int gap;
    do_rally(2'b01);
    n_tests++;
    if ({score_l, score_r, serve_side} !== {4'd1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL left_edge_1: got l=%0d r=%0d side=%b required 1/1/0", score_l, score_r, serve_side);
    end
    wait_start(found, ticks, gap);
    // Second rally, with a key press while in RALLY.
    halt = 1'b0;
    step();
    step();
    step();
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    halt = 1'b1;
    edg  = 2'b01;
    step();
    step();
    edg = 2'b00;
    n_tests++;
    if ({score_l, score_r, game_over} !== {4'd1, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL key_in_rally: got l=%0d r=%0d over=%b required 1/2/0", score_l, score_r, game_over);
    end
    wait_start(found, ticks, gap);
    n_tests++;
    if (found !== 1'b1) begin n_fail++; $display("FAIL serve_after_key_in_rally: got %b required 1", found); end
    do_rally(2'b01);
    n_tests++;
    if ({score_r, game_over, winner} !== {4'd3, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL win_point: got r=%0d over=%b win=%b required 3/0/00", score_r, game_over, winner);
    end
    step();
    n_tests++;
    if ({game_over, winner} !== {1'b1, 2'b10}) begin
      n_fail++;
      $display("FAIL game_over: got over=%b win=%b required 1/10", game_over, winner);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      n_tests++;
      if ({start, game_over, score_r} !== {1'b0, 1'b1, 4'd3}) begin
        n_fail++;
        $display("FAIL over_hold[%0d]: got start=%b over=%b r=%0d required 0/1/3", i, start, game_over, score_r);
      end
    end
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    n_tests++;
    if ({game_over, winner, score_l, score_r} !== 11'd0) begin
      n_fail++;
      $display("FAIL restart_clear: got over=%b win=%b l=%0d r=%0d required all 0", game_over, winner, score_l, score_r);
    end
    n_tests++;
    if (dut.state_q !== SERVE_WAIT) begin
      n_fail++;
      $display("FAIL restart_state: got %0d required %0d", dut.state_q, SERVE_WAIT);
    end
    wait_start(found, ticks, gap);
    n_tests++;
    if ({found, ticks[3:0]} !== {1'b1, 4'd2}) begin
      n_fail++;
      $display("FAIL restart_serve: got found=%b ticks=%0d required 1/2", found, ticks);
    end
  endtask

  task automatic test_reset_mid();
    bit found; int ticks; int gap;
    do_rally(2'b10);
    wait_start(found, ticks, gap);
    do_rally(2'b10);
    wait_start(found, ticks, gap);
    do_rally(2'b01);
    wait_start(found, ticks, gap);
    n_tests++;
    if ({found, score_l, score_r} !== {1'b1, 4'd2, 4'd1}) begin
      n_fail++;
      $display("FAIL mid_setup: got found=%b l=%0d r=%0d required 1/2/1", found, score_l, score_r);
    end
    step();
    step();
    n_tests++;
    if (dut.state_q !== WAIT_ACK) begin
      n_fail++;
      $display("FAIL mid_in_wait_ack: got %0d required %0d", dut.state_q, WAIT_ACK);
    end
    rst_n = 1'b1;
    step();
    n_tests++;
    if ({start, serve_side, score_l, score_r, game_over, winner, frame_tick} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b required 0", {start, serve_side, score_l, score_r, game_over, winner, frame_tick});
    end
    n_tests++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL mid_reset_state: got %0d required %0d", dut.state_q, IDLE);
    end
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_tests++;
      if (start !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_no_start[%0d]: got %b required 0", i, start);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_first_serve();
    test_point();
    test_retry();
    test_replay();
    test_game_over();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rally_sched.md
Name: rally_sched

Overview:
Match-level scheduler that sequences the ball-motion controller across a full game.
- Paces serves with a frame tick.
- Issues the one-cycle start request to the motion controller and checks that it is accepted.
- Reads the exit edge when the motion controller returns to halt, then keeps score and picks the next server.
- Declares the winner.
- Sits between the player start key/UI and the motion controller; score and winner outputs feed the display logic.

Parameters:
FRAME_DIV, 833333, clk cycles per frame tick (60 Hz at 50 MHz); counter width = $clog2(FRAME_DIV).
SERVE_DLY, 60, frame ticks between entering SERVE_WAIT and launch.
WIN_SCORE, 11, points needed to win; no deuce rule.
SCORE_W, 4, score counter width; WIN_SCORE must be < 2**SCORE_W.
ACK_TIMEOUT, 8, clk cycles to wait for halt to drop after a start pulse.

Ports:
clk  in  1  system clock.
rst_n  in  1  reset; synchronous, active-high, despite the name.
key_start  in  1  player start key, already debounced; level.
halt  in  1  motion controller idle/halted flag.
edg  in  2  motion controller exit edge: 00 none, 01 left edge, 10 right edge, 11 invalid.
start  out  1  one-cycle launch request to the motion controller.
serve_side  out  1  0 = left serves, 1 = right serves.
score_l  out  SCORE_W  left player score.
score_r  out  SCORE_W  right player score.
game_over  out  1  high while in OVER.
winner  out  2  00 none, 01 left, 10 right.
frame_tick  out  1  one-cycle pulse every FRAME_DIV cycles, free-running.

Behaviour:
- Reset values (all outputs and internal state, on the clk edge where rst_n=1):
  - start=0, serve_side=0, score_l=0, score_r=0, game_over=0, winner=00.
  - frame_tick=0, prescaler=0, serve counter=0, retry counter=0, key edge register=0, state=IDLE.
- Reset mid-operation: a reset in any state, including with start pending, forces IDLE on the next edge. No start pulse is emitted in that cycle.
- frame_tick: prescaler counts 0..FRAME_DIV-1; frame_tick=1 for exactly the cycle the prescaler equals FRAME_DIV-1. Runs in every state.
- key_start rising edge: registered; key_rise = key_start & ~key_q.
- States and transitions:
  - IDLE: on key_rise, clear scores, serve_side=0, winner=00, go SERVE_WAIT.
  - SERVE_WAIT: load the serve counter with SERVE_DLY on entry, decrement on each frame_tick. At 0, go LAUNCH, but only if halt=1. If halt=0, stay in SERVE_WAIT until halt=1.
  - LAUNCH: start=1 for this single cycle; clear the retry counter; go WAIT_ACK.
  - WAIT_ACK: if halt=0, go RALLY.
    - Otherwise increment the retry counter.
    - When it reaches ACK_TIMEOUT, go back to LAUNCH (re-issue start). Retries are unlimited.
  - RALLY: wait for halt=1. In that cycle, latch edg into edg_q and go SCORE.
  - SCORE (one cycle):
    - edg_q=01: score_r += 1, serve_side=0 (the losing side, left, serves).
    - edg_q=10: score_l += 1, serve_side=1.
    - edg_q=00 or 11: no score change, serve_side unchanged (break/invalid, point replayed).
    - Go CHECK.
  - CHECK (one cycle): if score_l == WIN_SCORE, winner=01, go OVER. Else if score_r == WIN_SCORE, winner=10, go OVER. Else go SERVE_WAIT.
  - OVER: game_over=1; scores and winner held. On key_rise, go IDLE-equivalent: clear scores and winner and go directly to SERVE_WAIT.
- key_rise is ignored in every state except IDLE and OVER.
- Scores are held at WIN_SCORE and never wrap. Only one score can change per SCORE cycle, so a simultaneous win is impossible.
- Latency:
  - key_rise to start: 1 (IDLE→SERVE_WAIT) + SERVE_DLY ticks + 1 cycle.
  - halt rise in RALLY to updated score outputs: 2 cycles.
  - Point scored to game_over: 3 cycles after halt rise.
- All outputs are registered.

Decomposition:
- Shared package pingpong_pkg holds:
  - State encoding localparams (IDLE, SERVE_WAIT, LAUNCH, WAIT_ACK, RALLY, SCORE, CHECK, OVER; 3 bits).
  - Edge codes EDG_NONE=00, EDG_LEFT=01, EDG_RIGHT=10.
  - Winner codes WIN_NONE, WIN_L, WIN_R.
- Sub-module frame_tick_gen(FRAME_DIV) produces frame_tick. It is shared later with the render block.

Test Plan:
All scenarios use FRAME_DIV=4, SERVE_DLY=2, WIN_SCORE=3, ACK_TIMEOUT=8.
1. Reset, halt=1, key_start pulse -> start pulses exactly once after 2 frame_ticks; serve_side=0; scores 0/0.
2. After launch, model drops halt next cycle, then raises it with edg=10 -> score_l=1, serve_side=1 two cycles after halt rise; next start follows 2 ticks later.
3. Model never drops halt after start -> start re-pulses every 9 cycles (LAUNCH + 8 WAIT_ACK); scores unchanged.
4. Rally ends with edg=00, then with edg=11 -> scores unchanged and serve_side unchanged both times; a relaunch occurs after each.
5. Three consecutive edg=01 rallies -> score_r=3, winner=10, game_over=1. A further key_start rise clears scores and winner, drops game_over and serves again; key_start during RALLY has no effect.
6. rst_n=1 during WAIT_ACK with scores 2/1 -> next cycle: state IDLE, all outputs at reset values, no start pulse.
